// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and the
// transmitter state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 10417;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with extra-MSB pointers; depth is 2**FIFO_AW.
// Flags decode straight from the registered pointers.
module byte_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wptr_q;
    logic [FIFO_AW:0] rptr_q;
    logic             wr_en_s;
    logic             rd_en_s;

    assign wr_en_s = push_i && !full_o;
    assign rd_en_s = pop_i && !empty_o;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= din_i;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= {(FIFO_AW+1){1'b0}};
            rptr_q <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wptr_q <= wptr_q + {{FIFO_AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rptr_q <= rptr_q + {{FIFO_AW{1'b0}}, 1'b1};
            end
        end
    end

    assign dout_o  = mem_q[rptr_q[FIFO_AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued 8N1 UART transmitter: rising edges of start enqueue a byte, the FSM
// drains the queue back-to-back onto an idle-high serial line, LSB first.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_AW      = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       pulse,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          start_q;
    logic          overflow_q;

    logic          capture_s;
    logic          push_s;
    logic          pop_s;
    logic          bit_end_s;
    logic [7:0]    fifo_dout_s;
    logic          full_s;
    logic          empty_s;

    assign capture_s = start && !start_q;
    assign push_s    = capture_s && !full_s;
    assign bit_end_s = (cnt_q == CNT_LAST);
    // Popping in the last STOP cycle lets the next START follow with no idle gap.
    assign pop_s     = !empty_s && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_STOP) && bit_end_s));

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_ni  (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (data),
        .dout_o  (fifo_dout_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Start edge detector and sticky drop flag; start_q resets high so a level
    // already present at reset release is not taken as a request.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            start_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            start_q    <= start;
            overflow_q <= overflow_q | (capture_s & full_s);
        end
    end

    // Transmit FSM with baud counter, shift register and registered line.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {CW{1'b0}};
                    if (pop_s) begin
                        shift_q <= fifo_dout_s;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_q   <= {CW{1'b0}};
                        bit_q   <= 3'd0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_q <= {CW{1'b0}};
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_q <= {CW{1'b0}};
                        if (pop_s) begin
                            shift_q <= fifo_dout_s;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CW{1'b0}};
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign pulse    = (state_q != ST_IDLE) && bit_end_s;
    assign busy     = (state_q != ST_IDLE) || !empty_s;
    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4: a queue-level
// model predicts pops and drops, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;

    localparam int C  = 4;
    localparam int FL = 10 * C;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       start  = 1'b0;
    logic       tx, busy, pulse, full, empty, overflow;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(3)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .data     (data),
        .start    (start),
        .tx       (tx),
        .busy     (busy),
        .pulse    (pulse),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endfunction

    typedef struct {
        logic [7:0] b;
        int         t0;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    int         next_pop_ok = 0;
    int         last_pop    = 0;
    bit         popped      = 0;
    bit         m_prev      = 1;
    bit         m_ovf       = 0;

    function automatic void model_clear();
        mq.delete();
        expq.delete();
        next_pop_ok = 0;
        last_pop    = 0;
        popped      = 0;
        m_prev      = 1;
        m_ovf       = 0;
    endfunction

    // One cycle of the queue model: pop and drop decisions see the queue as it
    // stood at the start of the cycle; a pushed byte is visible next cycle.
    function automatic void model_cycle(logic st, logic [7:0] d);
        bit   cap;
        bit   do_pop;
        bit   do_push;
        exp_t e;
        cap     = st && !m_prev;
        m_prev  = st;
        do_pop  = (mq.size() != 0) && (cyc >= next_pop_ok);
        do_push = cap && (mq.size() < 8);
        if (cap && mq.size() == 8) m_ovf = 1;
        if (do_pop) begin
            e.b  = mq.pop_front();
            e.t0 = cyc + 1;
            expq.push_back(e);
            last_pop    = cyc;
            popped      = 1;
            next_pop_ok = cyc + FL;
        end
        if (do_push) mq.push_back(d);
    endfunction

    function automatic bit model_busy();
        return (mq.size() != 0) || (popped && cyc <= last_pop + FL);
    endfunction

    task automatic step(input logic rst, input logic st, input logic [7:0] d);
        @(negedge sysclk);
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == 8);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, model_busy());
        start = st;
        data  = d;
        if (!rst && reset) begin
            reset = 1'b0;
            model_clear();
            #1;
            chk("rst_tx", tx, 1'b1);
            chk("rst_empty", empty, 1'b1);
        end else begin
            reset = rst;
            if (rst) model_cycle(st, d);
            else model_clear();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    // Line monitor: decodes each frame from its first low cycle and compares
    // start time, line contents and pulse pattern against the scoreboard.
    int         inf  = 0;
    int         fpos = 0;
    bit         have = 0;
    exp_t       cur;
    logic [FL-1:0] txv, plv, txe, ple;
    always @(negedge sysclk) begin
        if (!reset) begin
            inf = 0;
        end else if (inf == 0) begin
            if (tx === 1'b0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame", 1'b1, 1'b0);
                    have = 0;
                end else begin
                    cur  = expq.pop_front();
                    have = 1;
                    chk("frame_start", cyc, cur.t0);
                end
                inf  = 1;
                fpos = 0;
            end else begin
                chk("idle_pulse", pulse, 1'b0);
            end
        end
        if (reset && inf != 0) begin
            txv[fpos] = tx;
            plv[fpos] = pulse;
            fpos++;
            if (fpos == FL) begin
                inf = 0;
                if (have) begin
                    for (int k = 0; k < FL; k++) begin
                        if (k / C == 0) txe[k] = 1'b0;
                        else if (k / C == 9) txe[k] = 1'b1;
                        else txe[k] = cur.b[k / C - 1];
                        ple[k] = ((k % C) == C - 1);
                    end
                    chk("frame_line", txv, txe);
                    chk("frame_pulse", plv, ple);
                end
            end
        end
    end

    initial begin
        int budget;
        // Reset state
        idle(0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("reset_tx", tx, 1'b1);
        chk("reset_pulse", pulse, 1'b0);
        idle(3);

        // Single byte
        step(1'b1, 1'b1, 8'h41);
        idle(45);

        // Held strobe yields one byte
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h55);
        idle(50);

        // Burst of three on edges two cycles apart
        step(1'b1, 1'b1, 8'h48); step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h69); step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h21);
        idle(130);

        // Overflow: ten edges during the first frame
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'h30 + 8'(i));
            step(1'b1, 1'b0, 8'h00);
        end
        idle(9 * FL + 20);
        chk("overflow_sticky", overflow, 1'b1);

        // Reset during DATA with bytes still queued
        step(1'b1, 1'b1, 8'hA5); step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        idle(13);
        step(1'b0, 1'b0, 8'h00);
        idle(0);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        // start already high at release must not be captured
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h99);
        idle(60);
        chk("no_frame_after_reset", busy, 1'b0);
        step(1'b1, 1'b1, 8'h7E);
        idle(50);

        // Random traffic, occasionally bursting past the queue depth
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, 1'($urandom_range(0, 9) < 3), 8'($urandom));
        end

        budget = 0;
        while ((mq.size() != 0 || model_busy() || inf != 0) && budget < 3000) begin
            step(1'b1, 1'b0, 8'h00);
            budget++;
        end
        chk("drain_timeout", budget < 3000, 1'b1);
        idle(5);
        chk("scoreboard_empty", expq.size(), 0);
        chk("final_idle_tx", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
